// File: rtl/sobel_frame_ctrl.sv
// Raster-stream frame controller feeding a combinational 3x3 Sobel core.
// Optional `SOBEL_THRESH_EN adds a thresh input that binarises edge_out.
module sobel_frame_ctrl #(
    parameter int IMG_ROWS = 147,
    parameter int IMG_COLS = 143,
    parameter int PIX_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [PIX_W-1:0] core_z1,
    output logic [PIX_W-1:0] core_z2,
    output logic [PIX_W-1:0] core_z3,
    output logic [PIX_W-1:0] core_z4,
    output logic [PIX_W-1:0] core_z6,
    output logic [PIX_W-1:0] core_z7,
    output logic [PIX_W-1:0] core_z8,
    output logic [PIX_W-1:0] core_z9,
    input  logic [PIX_W-1:0] core_z_out,
    output logic [PIX_W-1:0] edge_out,
    output logic             edge_valid,
    input  logic             edge_ready,
`ifdef SOBEL_THRESH_EN
    input  logic [PIX_W-1:0] thresh,
`endif
    output logic             busy,
    output logic             done
);

    localparam int RW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam int CW = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state_q;
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    logic [PIX_W-1:0] top_q [3];
    logic [PIX_W-1:0] mid_q [3];
    logic [PIX_W-1:0] bot_q [3];
    logic [PIX_W-1:0] lb0_q [IMG_COLS];
    logic [PIX_W-1:0] lb1_q [IMG_COLS];
    logic [PIX_W-1:0] edge_q;
    logic             edge_vld_q;
    logic             cap_q;
    logic             busy_q;
    logic             done_q;

    logic             slot_free;
    logic             accept;
    logic             last_pix;
    logic             win_done;
    logic             cap_d;
    logic [PIX_W-1:0] cap_val;

    assign slot_free = !edge_vld_q || edge_ready;
    assign pix_ready = (state_q == RUN) && slot_free;
    assign accept    = pix_valid && pix_ready;
    assign last_pix  = (row_q == RW'(IMG_ROWS-1)) && (col_q == CW'(IMG_COLS-1));
    assign win_done  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    // A pending capture waits for the output slot; accepts are blocked meanwhile.
    assign cap_d     = win_done || (cap_q && !slot_free);

`ifdef SOBEL_THRESH_EN
    assign cap_val = (core_z_out >= thresh) ? '1 : '0;
`else
    assign cap_val = core_z_out;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            edge_q     <= '0;
            edge_vld_q <= 1'b0;
            cap_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                top_q[i] <= '0;
                mid_q[i] <= '0;
                bot_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_pix) state_q <= FLUSH;
                        if (col_q == CW'(IMG_COLS-1)) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (!cap_q && slot_free) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase

            if (accept) begin
                top_q[0] <= top_q[1];
                top_q[1] <= top_q[2];
                top_q[2] <= lb1_q[col_q];
                mid_q[0] <= mid_q[1];
                mid_q[1] <= mid_q[2];
                mid_q[2] <= lb0_q[col_q];
                bot_q[0] <= bot_q[1];
                bot_q[1] <= bot_q[2];
                bot_q[2] <= pix_in;
            end

            cap_q <= cap_d;
            if (cap_q && slot_free) begin
                edge_q     <= cap_val;
                edge_vld_q <= 1'b1;
            end else if (edge_ready) begin
                edge_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= pix_in;
        end
    end

    assign core_z1    = top_q[0];
    assign core_z2    = top_q[1];
    assign core_z3    = top_q[2];
    assign core_z4    = mid_q[0];
    assign core_z6    = mid_q[2];
    assign core_z7    = bot_q[0];
    assign core_z8    = bot_q[1];
    assign core_z9    = bot_q[2];
    assign edge_out   = edge_q;
    assign edge_valid = edge_vld_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench: 4x5 instance for sequencing/backpressure, default-size
// instance for a full flat frame; a behavioural Sobel core closes the loop.
module tb_sobel_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [7:0] thresh = 8'h40;

    int tests = 0;
    int fails = 0;

    // small 4x5 instance
    logic       s_start, s_pix_valid, s_pix_ready, s_edge_valid, s_edge_ready;
    logic       s_busy, s_done;
    logic [7:0] s_pix_in, s_zout, s_edge_out;
    logic [7:0] s_z1, s_z2, s_z3, s_z4, s_z6, s_z7, s_z8, s_z9;

    // default-size instance
    logic       b_start, b_pix_valid, b_pix_ready, b_edge_valid, b_edge_ready;
    logic       b_busy, b_done;
    logic [7:0] b_pix_in, b_zout, b_edge_out;
    logic [7:0] b_z1, b_z2, b_z3, b_z4, b_z6, b_z7, b_z8, b_z9;

    function automatic logic [7:0] sobel(input logic [7:0] z1, z2, z3, z4,
                                         input logic [7:0] z6, z7, z8, z9);
        int gx, gy, m;
        gx = (int'(z3) + 2*int'(z6) + int'(z9)) - (int'(z1) + 2*int'(z4) + int'(z7));
        gy = (int'(z7) + 2*int'(z8) + int'(z9)) - (int'(z1) + 2*int'(z2) + int'(z3));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = gx + gy;
        if (m > 255) m = 255;
        return 8'(m);
    endfunction

    function automatic logic [7:0] thr(input logic [7:0] v);
`ifdef SOBEL_THRESH_EN
        return (v >= thresh) ? 8'hFF : 8'h00;
`else
        return v;
`endif
    endfunction

    assign s_zout = sobel(s_z1, s_z2, s_z3, s_z4, s_z6, s_z7, s_z8, s_z9);
    assign b_zout = sobel(b_z1, b_z2, b_z3, b_z4, b_z6, b_z7, b_z8, b_z9);

    sobel_frame_ctrl #(.IMG_ROWS(4), .IMG_COLS(5), .PIX_W(8)) u_small (
        .clk(clk), .reset(rst), .start(s_start),
        .pix_in(s_pix_in), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
        .core_z1(s_z1), .core_z2(s_z2), .core_z3(s_z3), .core_z4(s_z4),
        .core_z6(s_z6), .core_z7(s_z7), .core_z8(s_z8), .core_z9(s_z9),
        .core_z_out(s_zout), .edge_out(s_edge_out), .edge_valid(s_edge_valid),
        .edge_ready(s_edge_ready),
`ifdef SOBEL_THRESH_EN
        .thresh(thresh),
`endif
        .busy(s_busy), .done(s_done)
    );

    sobel_frame_ctrl u_big (
        .clk(clk), .reset(rst), .start(b_start),
        .pix_in(b_pix_in), .pix_valid(b_pix_valid), .pix_ready(b_pix_ready),
        .core_z1(b_z1), .core_z2(b_z2), .core_z3(b_z3), .core_z4(b_z4),
        .core_z6(b_z6), .core_z7(b_z7), .core_z8(b_z8), .core_z9(b_z9),
        .core_z_out(b_zout), .edge_out(b_edge_out), .edge_valid(b_edge_valid),
        .edge_ready(b_edge_ready),
`ifdef SOBEL_THRESH_EN
        .thresh(thresh),
`endif
        .busy(b_busy), .done(b_done)
    );

    logic [7:0] img  [20];
    logic [7:0] gold [6];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Golden edges from the whole image, indexed by centre (r,c).
    task automatic build_gold();
        int k;
        k = 0;
        for (int r = 1; r <= 2; r++) begin
            for (int c = 1; c <= 3; c++) begin
                gold[k] = thr(sobel(img[(r-1)*5+c-1], img[(r-1)*5+c], img[(r-1)*5+c+1],
                                    img[r*5+c-1], img[r*5+c+1],
                                    img[(r+1)*5+c-1], img[(r+1)*5+c], img[(r+1)*5+c+1]));
                k++;
            end
        end
    endtask

    task automatic start_small();
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start     = 1'b0;
        s_pix_valid = 1'b0;
        chk("busy_after_start", 64'(s_busy), 64'd1);
    endtask

    task automatic run_small(input int vpct, input int rpct, input int stop_at,
                             input bit chk_win, input int start_cyc);
        int nxt, ne, nd, acc12, first_ev, done_cyc;
        bit hold, win_pend;
        logic [7:0] held;
        nxt = 0; ne = 0; nd = 0; acc12 = -1; first_ev = -1; done_cyc = 0;
        hold = 1'b0; win_pend = 1'b0; held = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            if (win_pend) begin
                chk("first_window", {s_z1, s_z2, s_z3, s_z4, s_z6, s_z7, s_z8, s_z9},
                    {8'd0, 8'd1, 8'd2, 8'd5, 8'd7, 8'd10, 8'd11, 8'd12});
                win_pend = 1'b0;
            end
            s_start      = (cyc == start_cyc);
            s_pix_valid  = (nxt < 20) && ($urandom_range(99) < vpct);
            s_pix_in     = s_pix_valid ? img[nxt] : 8'($urandom);
            s_edge_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            if (s_edge_valid && first_ev < 0) first_ev = cyc;
            if (hold) begin
                chk("stall_valid", 64'(s_edge_valid), 64'd1);
                chk("stall_data", 64'(s_edge_out), 64'(held));
            end
            hold = s_edge_valid && !s_edge_ready;
            held = s_edge_out;
            if (s_edge_valid && s_edge_ready) begin
                if (ne < 6) chk($sformatf("edge%0d", ne), 64'(s_edge_out), 64'(gold[ne]));
                ne++;
            end
            if (s_done) begin
                chk("busy_at_done", 64'(s_busy), 64'd0);
                nd++;
                done_cyc = cyc;
            end
            if (s_pix_valid && s_pix_ready) begin
                if (nxt == 12) begin
                    acc12 = cyc;
                    win_pend = chk_win;
                end
                nxt++;
                if (nxt == stop_at) break;
            end
            if (nd > 0 && cyc >= done_cyc + 3) break;
        end
        s_start = 1'b0;
        if (stop_at < 0) begin
            chk("accepts", 64'(nxt), 64'd20);
            chk("edge_count", 64'(ne), 64'd6);
            chk("done_pulses", 64'(nd), 64'd1);
            chk("ev_after_done", 64'(s_edge_valid), 64'd0);
            chk("busy_after_done", 64'(s_busy), 64'd0);
            if (chk_win) chk("first_edge_latency", 64'(first_ev), 64'(acc12 + 2));
        end
        s_pix_valid = 1'b0;
    endtask

    initial begin
        int bn, bd;
        rst = 1'b1;
        s_start = 0; s_pix_valid = 0; s_pix_in = 0; s_edge_ready = 1;
        b_start = 0; b_pix_valid = 0; b_pix_in = 0; b_edge_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_ready", 64'(s_pix_ready), 64'd0);
        chk("rst_edge_valid", 64'(s_edge_valid), 64'd0);
        chk("rst_edge_out", 64'(s_edge_out), 64'd0);
        chk("rst_busy_done", {62'd0, s_busy, s_done}, 64'd0);
        chk("rst_core_z", {s_z1, s_z2, s_z3, s_z4, s_z6, s_z7, s_z8, s_z9}, 64'd0);
        chk("rst_big_busy", 64'(b_busy), 64'd0);
        rst = 1'b0;

        // pix_valid in IDLE is never consumed
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            s_pix_valid = 1'b1;
            s_pix_in    = 8'hAA;
            @(negedge clk);
            chk("idle_pix_ready", {s_pix_ready, s_busy}, 64'd0);
        end

        // ramp frame, continuous stream
        for (int i = 0; i < 20; i++) img[i] = 8'(i);
        build_gold();
        start_small();
        run_small(100, 100, -1, 1'b1, -1);

        // random image, gaps and stalls, stray start during RUN
        for (int i = 0; i < 20; i++) img[i] = 8'($urandom);
        build_gold();
        start_small();
        run_small(60, 50, -1, 1'b0, 7);

        // reset mid-frame
        for (int i = 0; i < 20; i++) img[i] = 8'(i);
        build_gold();
        start_small();
        run_small(100, 100, 14, 1'b0, -1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 64'(s_busy), 64'd0);
        chk("midrst_edge_valid", 64'(s_edge_valid), 64'd0);
        chk("midrst_pix_ready", 64'(s_pix_ready), 64'd0);
        rst = 1'b0;
        start_small();
        run_small(100, 100, -1, 1'b1, -1);

        // full default-size flat frame
        @(posedge clk); #1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        bn = 0; bd = 0;
        for (int cyc = 0; cyc < 25000; cyc++) begin
            @(posedge clk); #1;
            b_pix_valid  = 1'b1;
            b_pix_in     = 8'h80;
            b_edge_ready = 1'b1;
            @(negedge clk);
            if (b_edge_valid && b_edge_ready) begin
                if (b_edge_out !== thr(8'h00)) chk("big_edge", 64'(b_edge_out), 64'(thr(8'h00)));
                bn++;
            end
            if (b_done) begin
                bd++;
                break;
            end
        end
        b_pix_valid = 1'b0;
        chk("big_edge_count", 64'(bn), 64'd20445);
        chk("big_done", 64'(bd), 64'd1);
        @(posedge clk); #1;
        chk("big_busy_after", {62'd0, b_busy, b_done}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
